// File: rtl/mux_rr_sel.sv
// mux_rr_sel: round-robin scheduler placed in front of a 4:1 data mux.
// Arbitrates four channel requests, drives the mux select, captures the mux
// output into a register and hands it downstream with a valid/ready handshake.
// The served channel gets a one-cycle ACK once its word is accepted.
//
// Optional build macro: MUX_RR_SEL_TIMEOUT_EN adds parameter TMO and a SEND
// timeout that drops the word and pulses ERR; without it ERR is tied low.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   REQ    in   [3:0] per-channel request (A=0, B=1, C=2, D=3)
//   YIN    in   [M1:0] mux output fed back for capture
//   READY  in   downstream accepts DOUT when READY && VALID
//   S      out  [1:0] registered mux select
//   DOUT   out  [M1:0] captured word
//   VALID  out  DOUT holds a word not yet accepted
//   ACK    out  [3:0] one-hot one-cycle pulse to the served channel
//   ERR    out  one-cycle timeout pulse (0 unless timeout is built in)
module mux_rr_sel #(
    parameter int unsigned M1 = 7
`ifdef MUX_RR_SEL_TIMEOUT_EN
    , parameter int unsigned TMO = 15
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  REQ,
    input  logic [M1:0] YIN,
    input  logic        READY,
    output logic [1:0]  S,
    output logic [M1:0] DOUT,
    output logic        VALID,
    output logic [3:0]  ACK,
    output logic        ERR
);

    typedef enum logic [1:0] {StIdle, StSel, StSend} state_e;

    state_e      state_q, state_d;
    logic [1:0]  s_q, s_d;
    logic [M1:0] dout_q, dout_d;
    logic        valid_q, valid_d;
    logic [3:0]  ack_q, ack_d;
    logic [1:0]  ptr_q, ptr_d;

    logic [1:0]  grant;
    logic        grant_found;
    logic [1:0]  idx;

`ifdef MUX_RR_SEL_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TMO + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    // Circular priority search starting at ptr; 2-bit index wraps naturally.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        idx         = '0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!grant_found && REQ[idx]) begin
                grant       = idx;
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        ack_d   = '0;
        ptr_d   = ptr_q;
`ifdef MUX_RR_SEL_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                if (grant_found) begin
                    s_d     = grant;
                    state_d = StSel;
                end
            end
            StSel: begin
                // Mux has had a full cycle to settle on the new select.
                dout_d  = YIN;
                valid_d = 1'b1;
                state_d = StSend;
`ifdef MUX_RR_SEL_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StSend: begin
                if (READY) begin
                    ack_d[s_q] = 1'b1;
                    valid_d    = 1'b0;
                    ptr_d      = s_q + 2'd1;
                    state_d    = StIdle;
                end
`ifdef MUX_RR_SEL_TIMEOUT_EN
                else if (cnt_q == CntW'(TMO - 1)) begin
                    // TMO-th consecutive stalled cycle: drop the word, move on.
                    valid_d = 1'b0;
                    ptr_d   = s_q + 2'd1;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            s_q     <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= '0;
            ptr_q   <= '0;
`ifdef MUX_RR_SEL_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            ptr_q   <= ptr_d;
`ifdef MUX_RR_SEL_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign S     = s_q;
    assign DOUT  = dout_q;
    assign VALID = valid_q;
    assign ACK   = ack_q;
`ifdef MUX_RR_SEL_TIMEOUT_EN
    assign ERR   = err_q;
`else
    assign ERR   = 1'b0;
`endif

endmodule
